// File: rtl/mem_fsm_pkg.sv
// Shared types and defaults for the load/store sequencer.
package mem_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_MAR, S_ST_DATA, S_ST_MDRW, S_ST_MEM,
    S_LD_MEM, S_LD_READ, S_LD_OUT, S_LD_WB, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] OPC_LOAD_DEF  = 4'b0011;
  localparam logic [3:0] OPC_STORE_DEF = 4'b0100;

  // Wait counter width; a disabled timeout still needs a 1-bit counter.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index -> one-hot enable (index 0 on the MSB) plus range check.
module reg_onehot_dec
  import mem_fsm_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int FLD_W    = 6
) (
  input  logic [FLD_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  // Out-of-range indices decode to all zeros and clear valid.
  always_comb begin
    valid  = (32'(idx) < NUM_REGS);
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(idx) == i) onehot[NUM_REGS-1-i] = 1'b1;
  end

endmodule

// File: rtl/mem_access_fsm.sv
// Load/store sequencer: drives bus strobes, memory handshake and register selects.
module mem_access_fsm
  import mem_fsm_pkg::*;
#(
  parameter int               INSTR_W     = 16,
  parameter int               OPC_W       = 4,
  parameter int               NUM_REGS    = 6,
  parameter logic [OPC_W-1:0] OPC_LOAD    = OPC_LOAD_DEF,
  parameter logic [OPC_W-1:0] OPC_STORE   = OPC_STORE_DEF,
  parameter int               MFC_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                abort,
  input  logic                MFC,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                pc_inc,
  output logic                mar_in,
  output logic                mdr_write_en,
  output logic                mdr_read_en,
  output logic                mdr_out,
  output logic                mem_en,
  output logic                RW,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in
);

  localparam int FLD_W = (INSTR_W - OPC_W) / 2;
  localparam int CW    = cnt_w(MFC_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((MFC_TIMEOUT > 0) ? MFC_TIMEOUT - 1 : 0);

  state_t               state, state_n;
  logic [INSTR_W-1:0]   instr_q, src;
  logic [CW-1:0]        wait_cnt;
  logic [OPC_W-1:0]     opc;
  logic                 opc_ok, accept, is_store, timed_out;
  logic [NUM_REGS-1:0]  oh1, oh2;
  logic                 v1, v2;

  // In IDLE the decoders look at the incoming word so the index check
  // happens on the start cycle; afterwards they follow the latched copy.
  // Outputs are all zero in IDLE, so the one-hots stay a function of instr_q.
  assign src       = (state == S_IDLE) ? instruction : instr_q;
  assign opc       = instruction[INSTR_W-1 -: OPC_W];
  assign opc_ok    = (opc == OPC_LOAD) || (opc == OPC_STORE);
  assign accept    = (state == S_IDLE) && start && opc_ok;
  assign is_store  = (instr_q[INSTR_W-1 -: OPC_W] == OPC_STORE);
  assign timed_out = (MFC_TIMEOUT > 0) && (wait_cnt == TO_LAST);

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .FLD_W(FLD_W)) u_dec_p1 (
    .idx(src[2*FLD_W-1 -: FLD_W]), .onehot(oh1), .valid(v1)
  );
  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .FLD_W(FLD_W)) u_dec_p2 (
    .idx(src[FLD_W-1:0]), .onehot(oh2), .valid(v2)
  );

  // State register and instruction latch; only an accepted start loads instr_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_q <= '0;
    end else begin
      state <= state_n;
      if (accept) instr_q <= instruction;
    end
  end

  // MFC wait counter: held at zero outside the wait states, so it restarts on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state != S_ST_MEM && state != S_LD_MEM)
      wait_cnt <= '0;
    else if (!MFC)
      wait_cnt <= wait_cnt + CW'(1);
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_n      = state;
    done         = 1'b0;
    err          = 1'b0;
    pc_inc       = 1'b0;
    mar_in       = 1'b0;
    mdr_write_en = 1'b0;
    mdr_read_en  = 1'b0;
    mdr_out      = 1'b0;
    mem_en       = 1'b0;
    RW           = 1'b0;
    rx_out       = '0;
    rx_in        = '0;
    case (state)
      S_IDLE:    if (accept) state_n = (v1 && v2) ? S_ADDR : S_ERR;
      S_ADDR:    begin pc_inc = 1'b1; rx_out = oh2; state_n = S_MAR; end
      S_MAR:     begin
                   mar_in  = 1'b1;
                   rx_out  = oh2;
                   state_n = is_store ? S_ST_DATA : S_LD_MEM;
                 end
      S_ST_DATA: begin rx_out = oh1; state_n = S_ST_MDRW; end
      S_ST_MDRW: begin mdr_write_en = 1'b1; rx_out = oh1; state_n = S_ST_MEM; end
      S_ST_MEM:  begin
                   mem_en = 1'b1;
                   if (MFC)            state_n = S_DONE;
                   else if (timed_out) state_n = S_ERR;
                 end
      S_LD_MEM:  begin
                   mem_en = 1'b1;
                   RW     = 1'b1;
                   if (MFC)            state_n = S_LD_READ;
                   else if (timed_out) state_n = S_ERR;
                 end
      S_LD_READ: begin mem_en = 1'b1; RW = 1'b1; mdr_read_en = 1'b1; state_n = S_LD_OUT; end
      S_LD_OUT:  begin mdr_out = 1'b1; RW = 1'b1; state_n = S_LD_WB; end
      S_LD_WB:   begin mdr_out = 1'b1; RW = 1'b1; rx_in = oh1; state_n = S_DONE; end
      S_DONE:    begin done = 1'b1; state_n = S_IDLE; end
      S_ERR:     begin err = 1'b1; state_n = S_IDLE; end
      default:   state_n = S_IDLE;
    endcase
    busy = (state != S_IDLE);
    // Abort cancels any sequence in flight; it has nothing to cancel in IDLE.
    if (abort && state != S_IDLE) state_n = S_IDLE;
  end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Randomized and directed bench for mem_access_fsm against a cycle-trace model.
module tb_mem_access_fsm;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start0 = 1'b0, start4 = 1'b0, abort = 1'b0, MFC = 1'b0;
  logic [15:0] instruction = '0;

  logic        busy0, done0, err0, pc0, mar0, mw0, mr0, mo0, me0, rw0;
  logic [5:0]  rxo0, rxi0;
  logic        busy4, done4, err4, pc4, mar4, mw4, mr4, mo4, me4, rw4;
  logic [5:0]  rxo4, rxi4;

  always #5 clk = ~clk;

  mem_access_fsm dut0 (
    .clk(clk), .rst(rst), .start(start0), .instruction(instruction), .abort(abort), .MFC(MFC),
    .busy(busy0), .done(done0), .err(err0), .pc_inc(pc0), .mar_in(mar0), .mdr_write_en(mw0),
    .mdr_read_en(mr0), .mdr_out(mo0), .mem_en(me0), .RW(rw0), .rx_out(rxo0), .rx_in(rxi0)
  );

  mem_access_fsm #(.MFC_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .instruction(instruction), .abort(abort), .MFC(MFC),
    .busy(busy4), .done(done4), .err(err4), .pc_inc(pc4), .mar_in(mar4), .mdr_write_en(mw4),
    .mdr_read_en(mr4), .mdr_out(mo4), .mem_en(me4), .RW(rw4), .rx_out(rxo4), .rx_in(rxi4)
  );

  // {busy,done,err,pc_inc,mar_in,mdr_write_en,mdr_read_en,mdr_out,mem_en,RW,rx_out,rx_in}
  wire [21:0] obs0 = {busy0, done0, err0, pc0, mar0, mw0, mr0, mo0, me0, rw0, rxo0, rxi0};
  wire [21:0] obs4 = {busy4, done4, err4, pc4, mar4, mw4, mr4, mo4, me4, rw4, rxo4, rxi4};

  int checks = 0, failures = 0;
  logic [21:0] exp_q[$];
  bit          mfc_q[$];

  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  // Register one-hot with register 0 on the MSB; negative means no select.
  function automatic logic [5:0] oh(input int r);
    logic [5:0] m;
    m = 6'b100000;
    return (r < 0) ? 6'b0 : (m >> r);
  endfunction

  function automatic logic [21:0] vec(input bit dn, er, pc, mar, mw, mr, mo, me, rw,
                                      input int rxo, input int rxi);
    return {1'b1, dn, er, pc, mar, mw, mr, mo, me, rw, oh(rxo), oh(rxi)};
  endfunction

  // Expected per-cycle output trace after an accepted start. d = number of
  // wait cycles without MFC before memory answers; to = timeout (0 = none).
  task automatic build(input logic [15:0] ins, input int d, input int to);
    int op, p1, p2;
    bit ld;
    op = int'(ins[15:12]); p1 = int'(ins[11:6]); p2 = int'(ins[5:0]);
    exp_q.delete(); mfc_q.delete();
    if (op != 3 && op != 4) return;
    if (p1 >= 6 || p2 >= 6) begin
      exp_q.push_back(vec(0,1,0,0,0,0,0,0,0,-1,-1)); mfc_q.push_back(0);
      return;
    end
    ld = (op == 3);
    exp_q.push_back(vec(0,0,1,0,0,0,0,0,0,p2,-1)); mfc_q.push_back(0);
    exp_q.push_back(vec(0,0,0,1,0,0,0,0,0,p2,-1)); mfc_q.push_back(0);
    if (!ld) begin
      exp_q.push_back(vec(0,0,0,0,0,0,0,0,0,p1,-1)); mfc_q.push_back(0);
      exp_q.push_back(vec(0,0,0,0,1,0,0,0,0,p1,-1)); mfc_q.push_back(0);
    end
    if (to == 0 || d < to) begin
      for (int k = 0; k <= d; k++) begin
        exp_q.push_back(vec(0,0,0,0,0,0,0,1,ld,-1,-1)); mfc_q.push_back(k == d);
      end
    end else begin
      for (int k = 0; k < to; k++) begin
        exp_q.push_back(vec(0,0,0,0,0,0,0,1,ld,-1,-1)); mfc_q.push_back(0);
      end
      exp_q.push_back(vec(0,1,0,0,0,0,0,0,0,-1,-1)); mfc_q.push_back(0);
      return;
    end
    if (ld) begin
      exp_q.push_back(vec(0,0,0,0,0,1,0,1,1,-1,-1)); mfc_q.push_back(0);
      exp_q.push_back(vec(0,0,0,0,0,0,1,0,1,-1,-1)); mfc_q.push_back(0);
      exp_q.push_back(vec(0,0,0,0,0,0,1,0,1,-1,p1)); mfc_q.push_back(0);
    end
    exp_q.push_back(vec(1,0,0,0,0,0,0,0,0,-1,-1)); mfc_q.push_back(0);
  endtask

  // One transaction: start at a posedge, then follow the expected trace cycle
  // by cycle; ab = cycle to abort in, ms = cycle to issue a stray start (-1 = none).
  task automatic run_txn(input string tag, input logic [15:0] ins, input int d,
                         input bit sel, input int ab, input int ms);
    int n;
    logic [21:0] o;
    build(ins, d, sel ? 4 : 15);
    if (ab >= 0 && ab < exp_q.size())
      while (exp_q.size() > ab + 1) begin void'(exp_q.pop_back()); void'(mfc_q.pop_back()); end
    n = exp_q.size();
    @(negedge clk);
    instruction = ins;
    if (sel) start4 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      MFC         = mfc_q[i];
      abort       = (i == ab);
      instruction = (i == ms) ? 16'h3042 : 16'($urandom);
      start0      = (!sel && i == ms);
      start4      = (sel && i == ms);
      @(negedge clk);
      o = sel ? obs4 : obs0;
      chk($sformatf("%s.c%0d", tag, i + 1), o, exp_q[i]);
      @(posedge clk); #1;
    end
    MFC = 1'b0; abort = 1'b0; start0 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    o = sel ? obs4 : obs0;
    chk($sformatf("%s.idle", tag), o, 22'h0);
  endtask

  initial begin
    logic [15:0] ins;
    int op;
    // Reset state
    #12;
    chk("rst0", obs0, 22'h0);
    chk("rst4", obs4, 22'h0);
    @(negedge clk); rst = 1'b0;

    // Directed scenarios
    run_txn("store4045", 16'h4045, 0, 0, -1, -1);
    run_txn("load30C2",  16'h30C2, 2, 0, -1, -1);
    run_txn("st_timeout", 16'h4045, 50, 1, -1, -1);
    run_txn("ld_timeout_edge", 16'h30C2, 3, 1, -1, -1);
    run_txn("bad_idx",   16'h31C0, 0, 0, -1, -1);
    run_txn("abort_ldmem", 16'h30C2, 5, 0, 3, -1);
    run_txn("restart_ign", 16'h4045, 0, 0, -1, 2);
    run_txn("opc1", 16'h1045, 0, 0, -1, -1);
    run_txn("st_noto", 16'h4000, 20, 0, -1, -1);

    // Reset in the middle of the memory wait clears mem_en at once
    @(negedge clk);
    instruction = 16'h4045; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_mem", obs0, vec(0,0,0,0,0,0,0,1,0,-1,-1));
    rst = 1'b1;
    #1 chk("async_rst", obs0, 22'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk) chk("after_rst", obs0, 22'h0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 9);
      ins[15:12] = (op < 4) ? 4'h3 : (op < 8) ? 4'h4 : 4'($urandom);
      ins[11:6]  = 6'($urandom_range(0, 7));
      ins[5:0]   = 6'($urandom_range(0, 7));
      run_txn($sformatf("rnd%0d", t), ins, $urandom_range(0, 6), 1'($urandom),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_fsm.md
Name: mem_access_fsm

Overview:
Parametrised load/store sequencer for the microcontroller datapath. It is the next generation of the memory-access control FSM.
- Latches the instruction on a start pulse and drives PC increment, MAR/MDR strobes, memory enable/RW and one-hot general-register select buses.
- Waits on memory-function-complete (MFC) with a configurable timeout, validates register indices, supports abort, and reports done/err.
- Sits between the instruction decoder/control unit and the memory/register-file bus drivers.

Parameters:
INSTR_W, 16, instruction width; opcode is the top OPC_W bits, and the remainder splits equally into param1 (upper) and param2 (lower), FLD_W = (INSTR_W-OPC_W)/2.
OPC_W, 4, opcode field width.
NUM_REGS, 6, number of general registers; width of the one-hot buses.
OPC_LOAD, 4'b0011, load opcode (param1 = destination register, param2 = register holding the address).
OPC_STORE, 4'b0100, store opcode (param1 = data register, param2 = address register).
MFC_TIMEOUT, 15, maximum cycles spent waiting for MFC; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle request; instruction is sampled with it.
instruction  in  INSTR_W  instruction word.
abort  in  1  synchronous cancel (fetch restart).
MFC  in  1  memory function complete.
busy  out  1  sequence in progress (any state except IDLE).
done  out  1  one-cycle pulse on successful completion.
err  out  1  one-cycle pulse on timeout or invalid register index.
pc_inc  out  1  increment program counter.
mar_in  out  1  load MAR from bus.
mdr_write_en  out  1  load MDR from bus.
mdr_read_en  out  1  load MDR from memory.
mdr_out  out  1  MDR drives bus.
mem_en  out  1  memory enable.
RW  out  1  1 = read, 0 = write.
rx_out  out  NUM_REGS  one-hot register output enable; index 0 maps to the MSB.
rx_in  out  NUM_REGS  one-hot register load enable; index 0 maps to the MSB.

Behaviour:
- Reset: state IDLE; instr_q = 0; wait_cnt = 0; all outputs 0.
- Outputs are Moore: decoded from the state and instr_q only.
- IDLE: all outputs 0.
  - On start with opcode LOAD/STORE: latch instr_q.
  - If param1 or param2 >= NUM_REGS, go to ERR.
  - Otherwise go to ADDR.
  - Any other opcode, or start=0: remain in IDLE with no pulse.
- Start pulses are ignored while busy. Later changes to instruction have no effect.
- ADDR: pc_inc=1; rx_out=onehot(param2).
- MAR: mar_in=1; rx_out=onehot(param2). Next state is ST_DATA (store) or LD_MEM (load).
- ST_DATA: rx_out=onehot(param1).
- ST_MDRW: mdr_write_en=1; rx_out=onehot(param1).
- ST_MEM: mem_en=1; RW=0.
  - Stay until MFC, then go to DONE.
- LD_MEM: mem_en=1; RW=1.
  - Stay until MFC, then go to LD_READ.
- LD_READ: mem_en=1; RW=1; mdr_read_en=1.
- LD_OUT: mdr_out=1; RW=1.
- LD_WB: mdr_out=1; RW=1; rx_in=onehot(param1).
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE.
- Timeout:
  - wait_cnt clears on entry to ST_MEM/LD_MEM and increments each wait cycle without MFC.
  - If MFC_TIMEOUT>0 and wait_cnt==MFC_TIMEOUT-1 with MFC=0, go to ERR. At most MFC_TIMEOUT cycles of mem_en.
  - Counter width is clog2(MFC_TIMEOUT+1), minimum 1.
- Simultaneous events: MFC and timeout in the same cycle → MFC wins.
- Priority: rst > abort > FSM transitions. Abort in any state → IDLE next edge, no done/err; abort in IDLE is a no-op.
- Reset mid-operation clears everything immediately, including asynchronous deassertion of mem_en.
- Latency with MFC high on the first wait cycle (start sampled at edge 0): store done in cycle 6; load done in cycle 7; busy deasserts the cycle after done.

Decomposition:
- mem_fsm_pkg holds the state enum and the default opcode constants.
- Sub-module reg_onehot_dec (index → MSB-first one-hot plus valid flag, parametrised on NUM_REGS/FLD_W). It is instantiated twice, once for param1 and once for param2.

Test Plan:
- Store 0x4045 (param1=1, param2=5), MFC high on the first wait cycle:
  - cycle 1: pc_inc, rx_out=000001.
  - cycle 2: mar_in.
  - cycles 3-4: rx_out=010000, with mdr_write_en in cycle 4.
  - cycle 5: mem_en, RW=0.
  - cycle 6: done.
- Load 0x30C2 (param1=3, param2=2), MFC delayed 3 cycles:
  - 3 cycles of mem_en/RW=1, then mdr_read_en.
  - Then mdr_out, then rx_in=000100 with mdr_out.
  - Then a done pulse.
- MFC_TIMEOUT=4, store with MFC never asserted → exactly 4 mem_en cycles, err pulse, back to IDLE, done never high.
- Load 0x31C0 (param1=7 ≥ NUM_REGS) → err the cycle after start; pc_inc never asserted.
- abort asserted during LD_MEM → all outputs 0 next cycle, busy=0, no done/err.
- A second start with a new instruction mid-store is ignored (the one-hot outputs keep the original indices); opcode 0x1 at start → no busy.
